// File: rtl/lsu.sv
// lsu: load/store unit bridging the core's memory stage to RAM port B,
// with alignment/range/funct3 checking and load data extension.
module lsu #(
    parameter int MEM_ADDR_WIDTH = 12
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_we,
    input  logic [2:0]                i_req_funct3,
    input  logic [31:0]               i_req_addr,
    input  logic [31:0]               i_req_wdata,
    output logic                      o_rsp_valid,
    input  logic                      i_rsp_ready,
    output logic [31:0]               o_rsp_rdata,
    output logic                      o_rsp_err,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                      o_mem_we,
    output logic [1:0]                o_mem_size,
    output logic [31:0]               o_mem_din,
    input  logic [31:0]               i_mem_dout
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
    state_t state, state_next;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [2:0] f3_q;
    logic idle, accept, misaligned, out_of_range, illegal, err_c;
    logic [31:0] ext;
    assign idle = state == IDLE;
    assign accept = idle & i_req_valid;
    assign out_of_range = (i_req_addr >> MEM_ADDR_WIDTH) != 32'd0;
    assign misaligned = (i_req_funct3[1:0] == 2'b01 & i_req_addr[0]) |
                        (i_req_funct3[1:0] == 2'b10 & |i_req_addr[1:0]);
    assign illegal = i_req_we ? i_req_funct3[2]
                              : (i_req_funct3[1:0] == 2'b11 | i_req_funct3 == 3'b110);
    assign err_c = misaligned | out_of_range | illegal;
    assign o_req_ready = idle;
    assign o_rsp_valid = state == RSP;
    // Gated by reset so a request held during reset cannot write the RAM.
    assign o_mem_we = accept & i_rst_n & i_req_we & ~err_c;
    assign o_mem_addr = idle ? i_req_addr[MEM_ADDR_WIDTH-1:0] : addr_q;
    assign o_mem_size = idle ? i_req_funct3[1:0] : f3_q[1:0];
    assign o_mem_din = i_req_wdata;
    always_comb begin
        state_next = state;
        state_next = idle ? (i_req_valid ? ((err_c | i_req_we) ? RSP : RD_WAIT) : IDLE) :
                     state == RD_WAIT ? RSP :
                     (i_rsp_ready ? IDLE : RSP);
    end
    // RAM returns bytes starting at the addressed byte, so lanes are always low-aligned.
    always_comb begin
        ext = i_mem_dout;
        ext = f3_q == 3'b000 ? {{24{i_mem_dout[7]}}, i_mem_dout[7:0]} :
              f3_q == 3'b100 ? {24'd0, i_mem_dout[7:0]} :
              f3_q == 3'b001 ? {{16{i_mem_dout[15]}}, i_mem_dout[15:0]} :
              f3_q == 3'b101 ? {16'd0, i_mem_dout[15:0]} :
              i_mem_dout;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            f3_q <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err <= 1'b0;
        end else if (accept) begin
            if (err_c | i_req_we) begin
                o_rsp_rdata <= '0;
                o_rsp_err <= err_c;
            end else begin
                addr_q <= i_req_addr[MEM_ADDR_WIDTH-1:0];
                f3_q <= i_req_funct3;
            end
        end else if (state == RD_WAIT) begin
            o_rsp_rdata <= ext;
            o_rsp_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a byte-array RAM and a spec-level
// reference memory predicting every response.
module tb_lsu;
    localparam int AW = 12;
    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [2:0] req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic req_ready, rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;
    logic [1:0] mem_size;
    logic [7:0] ram [4096];
    logic [7:0] ref_mem [4096];
    int total = 0, passed = 0;
    bit cmp_on = 1'b0;
    logic exp_valid = 1'b0, exp_ready = 1'b1, exp_we = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    lsu #(.MEM_ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_funct3(req_funct3),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_size(mem_size), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Port B of the RAM: byte-addressed, registered read starting at the addressed byte.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_din[7:0];
            if (mem_size != 2'b00) ram[mem_addr + 12'd1] <= mem_din[15:8];
            if (mem_size == 2'b10) begin
                ram[mem_addr + 12'd2] <= mem_din[23:16];
                ram[mem_addr + 12'd3] <= mem_din[31:24];
            end
        end
        mem_dout <= {ram[mem_addr + 12'd3], ram[mem_addr + 12'd2],
                     ram[mem_addr + 12'd1], ram[mem_addr]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit mis, oor, ill;
        mis = (f3 == 3'b001 || f3 == 3'b101) ? a[0] : (f3 == 3'b010) ? (a % 4 != 0) : 1'b0;
        oor = a >= 32'(1 << AW);
        ill = we ? f3[2] : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        return mis | oor | ill;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a);
        int ai;
        int b0, b1, b2, b3;
        ai = int'(a);
        b0 = int'(ref_mem[ai % 4096]);
        b1 = int'(ref_mem[(ai + 1) % 4096]);
        b2 = int'(ref_mem[(ai + 2) % 4096]);
        b3 = int'(ref_mem[(ai + 3) % 4096]);
        case (f3)
            3'b000: return 32'(b0 >= 128 ? b0 - 256 : b0);
            3'b100: return 32'(b0);
            3'b001: return 32'((b1 * 256 + b0) >= 32768 ? b1 * 256 + b0 - 65536 : b1 * 256 + b0);
            3'b101: return 32'(b1 * 256 + b0);
            default: return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        endcase
    endfunction

    function automatic void m_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = f3 == 3'b000 ? 1 : f3 == 3'b001 ? 2 : 4;
        for (int k = 0; k < n; k++) ref_mem[(int'(a) + k) % 4096] = 8'(d >> (8 * k));
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("req_ready", 32'(req_ready), 32'(exp_ready));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_valid) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_err", 32'(rsp_err), 32'(exp_err));
            end
        end
    end

    // Starts and ends at #1 after an edge with the DUT in IDLE.
    task automatic req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit lit_en,
                       input logic [31:0] lit);
        bit e;
        logic [31:0] r;
        e = m_err(we, f3, a);
        r = (we || e) ? 32'd0 : m_load(f3, a);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        exp_ready = 1'b1; exp_valid = 1'b0; exp_we = we & ~e;
        if (we && !e) m_store(f3, a, d);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_we = 1'b0;
        if (!we && !e) begin
            @(posedge clk); #1;
        end
        exp_valid = 1'b1; exp_rdata = r; exp_err = e;
        if (lit_en) chk("literal", rsp_rdata, lit);
        if (hold > 0) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h100; req_wdata = 32'h5555_5555;
            repeat (hold) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1; req_valid = 1'b0;
        end
        @(posedge clk); #1;
        exp_valid = 1'b0; exp_ready = 1'b1;
    endtask

    initial begin
        cmp_on = 1'b1;
        #2;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_size", 32'(mem_size), 32'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        req(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1, 32'd0);
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF);
        req(0, 3'b000, 32'h100, 32'd0, 0, 1, 32'hFFFF_FFEF);
        req(0, 3'b100, 32'h103, 32'd0, 0, 1, 32'h0000_00DE);
        req(0, 3'b001, 32'h102, 32'd0, 0, 1, 32'hFFFF_DEAD);
        req(0, 3'b101, 32'h100, 32'd0, 0, 1, 32'h0000_BEEF);
        req(0, 3'b010, 32'h100, 32'd0, 4, 1, 32'hDEAD_BEEF);
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF);
        req(1, 3'b001, 32'h102, 32'h0000_1234, 0, 0, 32'd0);
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'h1234_BEEF);
        req(1, 3'b000, 32'h101, 32'h0000_00A5, 0, 0, 32'd0);
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'h1234_A5EF);
        req(0, 3'b101, 32'h101, 32'd0, 0, 1, 32'd0);
        req(0, 3'b010, 32'h102, 32'd0, 0, 1, 32'd0);
        req(1, 3'b010, 32'h1000, 32'hFFFF_FFFF, 0, 1, 32'd0);
        req(0, 3'b011, 32'h100, 32'd0, 0, 1, 32'd0);
        req(1, 3'b100, 32'h104, 32'h1111_1111, 0, 1, 32'd0);
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'h1234_A5EF);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        exp_ready = 1'b1; exp_we = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0; exp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req(0, 3'b010, 32'h100, 32'd0, 0, 1, 32'h1234_A5EF);
        req(0, 3'b000, 32'h101, 32'd0, 0, 1, 32'hFFFF_FFA5);
        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
